// File: rtl/common_bus_datapath.sv
// common_bus_datapath: datapath slice of the 8-bit common-bus CPU.
// Owns PC, IR, the register-select field, the register file and the two
// ALU operand latches. Every cycle one source drives the shared 8-bit bus.
// Every enabled destination loads from that bus on the rising clock edge.
// Optional feature macro: DATAPATH_R0_ZERO_EN (rf[0] hardwired to 0x00).

package common_bus_pkg;
    typedef enum logic [2:0] {
        ZERO      = 3'd0,
        IR_R1     = 3'd1,
        IR_R2     = 3'd2,
        IR_RD     = 3'd3,
        RF        = 3'd4,
        ALU_BUS   = 3'd5,
        PC_PLUS_4 = 3'd6
    } data_bus_t;
endpackage

module common_bus_datapath
    import common_bus_pkg::*;
#(
    parameter int RF_DEPTH = 8,
    parameter int PC_STEP  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  data_bus_t   data_bus_sel,
    input  logic        pc_load_en,
    input  logic        ir_load_en,
    input  logic        rf_write_read,
    input  logic        alu_src1_load_en,
    input  logic        alu_src2_load_en,
    input  logic        sel_field_load_en,
    input  logic [31:0] imem_data,
    output logic [7:0]  imem_addr,
    output logic        imm_instruction,
    output logic [7:0]  bus_out
);
    localparam int IDX_W = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;
    localparam logic [7:0] PC_INC = 8'(PC_STEP);
`ifdef DATAPATH_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    logic [7:0]          pc_q, pc_d;
    logic [31:0]         ir_q, ir_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic [7:0]          src1_q, src1_d;
    logic [7:0]          src2_q, src2_d;
    logic [7:0]          rf_q [RF_DEPTH];
    logic [7:0]          rf_d [RF_DEPTH];
    logic [RF_DEPTH-1:0] rf_we;

    logic [7:0] bus;
    logic [7:0] alu_result;
    logic [7:0] rf_rd_data;
    logic [3:0] alu_op;
    logic       unused_ir_reserved;

    assign alu_op             = ir_q[31:28];
    // Bits [26:24] of the instruction word are reserved and have no consumer.
    assign unused_ir_reserved = ^ir_q[26:24];

    // ALU: 8-bit result, carries and overflow simply fall off the top.
    always_comb begin
        alu_result = 8'h00;
        case (alu_op)
            4'd0:    alu_result = src1_q + src2_q;
            4'd1:    alu_result = src1_q - src2_q;
            4'd2:    alu_result = src1_q & src2_q;
            4'd3:    alu_result = src1_q | src2_q;
            4'd4:    alu_result = src1_q ^ src2_q;
            4'd5:    alu_result = src1_q << src2_q[2:0];
            4'd6:    alu_result = src1_q >> src2_q[2:0];
            4'd7:    alu_result = src2_q;
            default: alu_result = 8'h00;
        endcase
    end

    // Register-file read port addressed by the select field; entry 0 reads zero when hardwired.
    always_comb begin
        rf_rd_data = rf_q[sel_q];
        if (R0_ZERO && (sel_q == '0)) begin
            rf_rd_data = 8'h00;
        end
    end

    // Bus source mux; unused encodings park the bus at zero.
    always_comb begin
        bus = 8'h00;
        case (data_bus_sel)
            ZERO:      bus = 8'h00;
            IR_R1:     bus = ir_q[15:8];
            IR_R2:     bus = ir_q[7:0];
            IR_RD:     bus = ir_q[23:16];
            RF:        bus = rf_rd_data;
            ALU_BUS:   bus = alu_result;
            PC_PLUS_4: bus = pc_q + PC_INC;
            default:   bus = 8'h00;
        endcase
    end

    // Per-entry write strobes; a hardwired entry 0 never accepts a write.
    generate
        for (genvar gi = 0; gi < RF_DEPTH; gi++) begin : g_rf_we
            assign rf_we[gi] = rf_write_read && (sel_q == IDX_W'(gi)) && !(R0_ZERO && (gi == 0));
        end
    endgenerate

    // Next-state selection: each destination independently takes the bus (IR takes imem).
    always_comb begin
        pc_d   = pc_load_en        ? bus              : pc_q;
        ir_d   = ir_load_en        ? imem_data        : ir_q;
        src1_d = alu_src1_load_en  ? bus              : src1_q;
        src2_d = alu_src2_load_en  ? bus              : src2_q;
        sel_d  = sel_field_load_en ? bus[IDX_W-1:0]   : sel_q;
        for (int i = 0; i < RF_DEPTH; i++) begin
            rf_d[i] = rf_we[i] ? bus : rf_q[i];
        end
    end

    // State registers; reset may strike mid-instruction and clears everything.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q   <= 8'h00;
            ir_q   <= 32'h0000_0000;
            sel_q  <= '0;
            src1_q <= 8'h00;
            src2_q <= 8'h00;
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_q[i] <= 8'h00;
            end
        end else begin
            pc_q   <= pc_d;
            ir_q   <= ir_d;
            sel_q  <= sel_d;
            src1_q <= src1_d;
            src2_q <= src2_d;
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    assign imem_addr       = pc_q;
    assign imm_instruction = ir_q[27];
    assign bus_out         = bus;

endmodule

// File: tb/tb_common_bus_datapath.sv
// tb_common_bus_datapath: scoreboard bench for common_bus_datapath.
// The driver issues one control word per cycle and pushes the expected
// bus_out / imem_addr / imm_instruction; a monitor pops and compares on
// the falling edge. Expectations come from an array-based model of the
// programmer-visible registers, or from fixed constants in directed cases.
`timescale 1ns/1ps

module tb_common_bus_datapath;
    import common_bus_pkg::*;

`ifdef DATAPATH_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    // Enable bit order: {pc, ir, rf_write, src1, src2, sel}
    localparam logic [5:0] EN_NONE = 6'b000000;
    localparam logic [5:0] EN_PC   = 6'b100000;
    localparam logic [5:0] EN_IR   = 6'b010000;
    localparam logic [5:0] EN_RF   = 6'b001000;
    localparam logic [5:0] EN_S1   = 6'b000100;
    localparam logic [5:0] EN_S2   = 6'b000010;
    localparam logic [5:0] EN_SEL  = 6'b000001;

    localparam logic [2:0] S_ZERO = 3'd0;
    localparam logic [2:0] S_R1   = 3'd1;
    localparam logic [2:0] S_R2   = 3'd2;
    localparam logic [2:0] S_RD   = 3'd3;
    localparam logic [2:0] S_RF   = 3'd4;
    localparam logic [2:0] S_ALU  = 3'd5;
    localparam logic [2:0] S_PC4  = 3'd6;
    localparam logic [2:0] S_BAD  = 3'd7;

    logic        clock = 1'b0;
    logic        reset;
    data_bus_t   data_bus_sel;
    logic        pc_load_en, ir_load_en, rf_write_read;
    logic        alu_src1_load_en, alu_src2_load_en, sel_field_load_en;
    logic [31:0] imem_data;
    logic [7:0]  imem_addr;
    logic        imm_instruction;
    logic [7:0]  bus_out;

    common_bus_datapath #(.RF_DEPTH(8), .PC_STEP(4)) dut (
        .clock             (clock),
        .reset             (reset),
        .data_bus_sel      (data_bus_sel),
        .pc_load_en        (pc_load_en),
        .ir_load_en        (ir_load_en),
        .rf_write_read     (rf_write_read),
        .alu_src1_load_en  (alu_src1_load_en),
        .alu_src2_load_en  (alu_src2_load_en),
        .sel_field_load_en (sel_field_load_en),
        .imem_data         (imem_data),
        .imem_addr         (imem_addr),
        .imm_instruction   (imm_instruction),
        .bus_out           (bus_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] bus;
        logic [7:0] addr;
        logic       imm;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   txn      = 0;

    // Reference model: programmer-visible state as plain integers.
    int          m_pc, m_sel, m_src1, m_src2;
    logic [31:0] m_ir;
    int          m_rf[8];

    function automatic int alu_ref(int op, int a, int b);
        case (op)
            0: return (a + b) % 256;
            1: return (a - b + 256) % 256;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return (a << (b % 8)) % 256;
            6: return a >> (b % 8);
            7: return b;
            default: return 0;
        endcase
    endfunction

    function automatic int model_bus(int src);
        case (src)
            1: return int'(m_ir[15:8]);
            2: return int'(m_ir[7:0]);
            3: return int'(m_ir[23:16]);
            4: return (R0Z && m_sel == 0) ? 0 : m_rf[m_sel];
            5: return alu_ref(int'(m_ir[31:28]), m_src1, m_src2);
            6: return (m_pc + 4) % 256;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 0; m_sel = 0; m_src1 = 0; m_src2 = 0; m_ir = 32'h0;
        for (int i = 0; i < 8; i++) m_rf[i] = 0;
    endtask

    // One control word for one cycle. want_bus / want_pc >= 0 override the model.
    task automatic step(input logic [2:0] src, input logic [5:0] en, input logic [31:0] imem,
                        input int want_bus, input int want_pc, input string tag);
        int   b;
        exp_t e;
        data_bus_sel = data_bus_t'(src);
        {pc_load_en, ir_load_en, rf_write_read,
         alu_src1_load_en, alu_src2_load_en, sel_field_load_en} = en;
        imem_data = imem;
        b      = model_bus(int'(src));
        e.bus  = (want_bus >= 0) ? 8'(want_bus) : 8'(b);
        e.addr = (want_pc >= 0) ? 8'(want_pc) : 8'(m_pc);
        e.imm  = m_ir[27];
        e.tag  = tag;
        exp_q.push_back(e);
        @(posedge clock);
        if (en[5]) m_pc = b;
        if (en[4]) m_ir = imem;
        if (en[3] && !(R0Z && m_sel == 0)) m_rf[m_sel] = b;
        if (en[2]) m_src1 = b;
        if (en[1]) m_src2 = b;
        if (en[0]) m_sel = b % 8;
        #1;
    endtask

    task automatic write_rf(input int idx, input int val);
        step(S_ZERO, EN_IR, {16'h0000, 8'(idx), 8'(val)}, -1, -1, "wr_fetch");
        step(S_R1, EN_SEL, $urandom, -1, -1, "wr_sel");
        step(S_R2, EN_RF, $urandom, -1, -1, "wr_data");
    endtask

    task automatic check_rf(input int idx, input int want, input string tag);
        step(S_ZERO, EN_IR, {16'h0000, 8'(idx), 8'h00}, -1, -1, "rd_fetch");
        step(S_R1, EN_SEL, $urandom, -1, -1, "rd_sel");
        step(S_RF, EN_NONE, $urandom, want, -1, tag);
    endtask

    // Reset pulse strictly between clock edges; outputs are checked while it is held.
    task automatic pulse_reset(input logic [2:0] src, input string tag);
        exp_t e;
        data_bus_sel = data_bus_t'(src);
        {pc_load_en, ir_load_en, rf_write_read,
         alu_src1_load_en, alu_src2_load_en, sel_field_load_en} = EN_NONE;
        #2 reset = 1'b1;
        model_reset();
        e.bus = 8'h00; e.addr = 8'h00; e.imm = 1'b0; e.tag = tag;
        exp_q.push_back(e);
        @(negedge clock);
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    // Monitor: every cycle with a pending expectation compares the three outputs.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            txn++;
            checks += 3;
            if (bus_out !== mon_e.bus) begin
                failures++;
                $display("FAIL %s bus_out got=%02h want=%02h", mon_e.tag, bus_out, mon_e.bus);
            end
            if (imem_addr !== mon_e.addr) begin
                failures++;
                $display("FAIL %s imem_addr got=%02h want=%02h", mon_e.tag, imem_addr, mon_e.addr);
            end
            if (imm_instruction !== mon_e.imm) begin
                failures++;
                $display("FAIL %s imm_instruction got=%0b want=%0b", mon_e.tag, imm_instruction, mon_e.imm);
            end
            $display("txn %0d %s bus=%02h addr=%02h imm=%0b", txn, mon_e.tag, bus_out, imem_addr, imm_instruction);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish within 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rsrc;
        logic [5:0]  ren;
        reset = 1'b1;
        data_bus_sel = ZERO;
        {pc_load_en, ir_load_en, rf_write_read,
         alu_src1_load_en, alu_src2_load_en, sel_field_load_en} = EN_NONE;
        imem_data = 32'h0;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        step(S_ZERO, EN_NONE, 32'hFFFF_FFFF, 0, 0, "reset_state");

        // Reset mid-write: rf[3] is visible, then cleared by an asynchronous pulse
        write_rf(3, 8'h5A);
        step(S_RF, EN_NONE, 32'h0, 8'h5A, -1, "rf3_before_reset");
        pulse_reset(S_RF, "reset_async");
        check_rf(3, 8'h00, "rf3_after_reset");

        // Register ADD, 8-step sequence, 0x70 + 0x95 wraps to 0x05
        write_rf(1, 8'h70);
        write_rf(2, 8'h95);
        step(S_ZERO, EN_IR,  32'h0003_0102, -1, 0, "add_fetch");
        step(S_R1,   EN_SEL, $urandom, 8'h01, -1, "add_sel_r1");
        step(S_RF,   EN_S1,  $urandom, 8'h70, -1, "add_src1");
        step(S_R2,   EN_SEL, $urandom, 8'h02, -1, "add_sel_r2");
        step(S_RF,   EN_S2,  $urandom, 8'h95, -1, "add_src2");
        step(S_RD,   EN_SEL, $urandom, 8'h03, -1, "add_sel_rd");
        step(S_ALU,  EN_RF,  $urandom, 8'h05, -1, "add_writeback");
        step(S_PC4,  EN_PC,  $urandom, 8'h04, 0, "add_pc_inc");
        step(S_ZERO, EN_NONE, $urandom, 0, 4, "add_pc_after");
        check_rf(3, 8'h05, "add_rf3");

        // Immediate SUB, 7-step sequence, 0x10 - 0x20 = 0xF0
        write_rf(1, 8'h10);
        step(S_ZERO, EN_IR,  32'h1804_0120, -1, 4, "sub_fetch");
        step(S_R1,   EN_SEL, $urandom, 8'h01, -1, "sub_sel_r1");
        step(S_RF,   EN_S1,  $urandom, 8'h10, -1, "sub_src1");
        step(S_R2,   EN_S2,  $urandom, 8'h20, -1, "sub_imm");
        step(S_RD,   EN_SEL, $urandom, 8'h04, -1, "sub_sel_rd");
        step(S_ALU,  EN_RF,  $urandom, 8'hF0, -1, "sub_writeback");
        step(S_PC4,  EN_PC,  $urandom, 8'h08, 4, "sub_pc_inc");
        check_rf(4, 8'hF0, "sub_rf4");

        // PC wrap: 0xFC + 4 -> 0x00
        step(S_ZERO, EN_IR, 32'h0000_00FC, -1, -1, "wrap_fetch");
        step(S_R2,   EN_PC, $urandom, 8'hFC, -1, "wrap_set_pc");
        step(S_PC4,  EN_PC, $urandom, 8'h00, 8'hFC, "wrap_pc_inc");
        step(S_ZERO, EN_NONE, $urandom, 0, 0, "wrap_addr");

        // Simultaneous loads from one bus value, then unknown source encoding
        write_rf(7, 8'h99);
        write_rf(2, 8'h11);
        step(S_ZERO, EN_IR, 32'h7000_0037, -1, -1, "simul_fetch");
        step(S_R2, EN_S1 | EN_S2 | EN_SEL, $urandom, 8'h37, -1, "simul_load");
        step(S_ALU,  EN_NONE, $urandom, 8'h37, -1, "simul_src2");
        step(S_RF,   EN_NONE, $urandom, 8'h99, -1, "simul_sel7");
        step(S_ZERO, EN_IR, 32'h0000_0037, -1, -1, "simul_fetch_add");
        step(S_ALU,  EN_NONE, $urandom, 8'h6E, -1, "simul_src1");
        step(S_BAD,  EN_NONE, $urandom, 8'h00, -1, "bad_sel");

        // Register 0 behaviour depends on the build option
        write_rf(0, 8'hAA);
        step(S_RF, EN_NONE, $urandom, R0Z ? 8'h00 : 8'hAA, -1, "r0_read");

        // Randomized control words against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                pulse_reset(3'($urandom_range(0, 7)), "rand_reset");
            end else begin
                rsrc = 3'($urandom_range(0, 7));
                ren  = 6'($urandom);
                step(rsrc, ren, $urandom, -1, -1, "rand");
            end
        end

        @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
